// File: rtl/lpc_host_sequencer_pkg.sv
// Shared encodings for the LPC host sequencer.
// Host state codes mirror the host FSM; sequencer codes are local.
package lpc_host_sequencer_pkg;

  localparam logic [4:0] LPC_ST_IDLE        = 5'h00;
  localparam logic [4:0] LPC_ST_FORCE_RESET = 5'h10;

  typedef enum logic [2:0] {
    LPC_SEQ_ST_RST_HOLD = 3'd0,
    LPC_SEQ_ST_RELEASE  = 3'd1,
    LPC_SEQ_ST_IDLE     = 3'd2,
    LPC_SEQ_ST_FRAME    = 3'd3,
    LPC_SEQ_ST_STATUS   = 3'd4,
    LPC_SEQ_ST_WAIT     = 3'd5,
    LPC_SEQ_ST_RESP_OK  = 3'd6,
    LPC_SEQ_ST_RESP_ERR = 3'd7
  } lpc_seq_state_t;

  typedef struct packed {
    logic        write;
    logic        memory;
    logic [15:0] addr;
    logic [7:0]  data;
  } lpc_req_t;

endpackage

// File: rtl/lpc_host_sequencer.sv
// Command sequencer in front of the LPC host FSM: reset bring-up,
// frame/status pulses, completion detection, timeout and recovery.
module lpc_host_sequencer
  import lpc_host_sequencer_pkg::*;
#(
  parameter int RST_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic        req_memory_i,
  input  logic [15:0] req_addr_i,
  input  logic [7:0]  req_data_i,
  output logic        rsp_valid_o,
  output logic [7:0]  rsp_data_o,
  output logic        rsp_error_o,
  output logic        busy_o,
  output logic [15:0] ctrl_addr_o,
  output logic [7:0]  ctrl_data_o,
  output logic        ctrl_nrst_o,
  output logic        ctrl_lframe_o,
  output logic        ctrl_rd_status_o,
  output logic        ctrl_wr_status_o,
  output logic        ctrl_memory_cycle_o,
  input  logic [7:0]  ctrl_data_i,
  input  logic        ctrl_ready_i,
  input  logic [4:0]  ctrl_host_state_i
);

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lpc_seq_state_t   state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             armed_q, armed_n;
  lpc_req_t         req_q, req_d;

  logic host_idle, host_frst, accept, done, stat;
  logic nrst_d, lframe_d, rd_d, wr_d;
  logic rsp_valid_d, rsp_error_d, busy_d;
  logic [7:0] rsp_data_d;

  assign host_idle   = ctrl_host_state_i == LPC_ST_IDLE;
  assign host_frst   = ctrl_host_state_i == LPC_ST_FORCE_RESET;
  assign req_ready_o = (state_q == LPC_SEQ_ST_IDLE) && host_idle;
  assign accept      = req_valid_i && req_ready_o;
  // ready is level and stale from the last cycle until it drops once
  assign done        = armed_q && ctrl_ready_i;

  assign ctrl_addr_o         = req_q.addr;
  assign ctrl_data_o         = req_q.data;
  assign ctrl_memory_cycle_o = req_q.memory;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q          <= LPC_SEQ_ST_RST_HOLD;
      cnt_q            <= '0;
      armed_q          <= 1'b0;
      req_q            <= '0;
      ctrl_nrst_o      <= 1'b0;
      ctrl_lframe_o    <= 1'b1;
      ctrl_rd_status_o <= 1'b0;
      ctrl_wr_status_o <= 1'b0;
      rsp_valid_o      <= 1'b0;
      rsp_error_o      <= 1'b0;
      rsp_data_o       <= '0;
      busy_o           <= 1'b1;
    end else begin
      state_q          <= state_n;
      cnt_q            <= cnt_n;
      armed_q          <= armed_n;
      req_q            <= req_d;
      ctrl_nrst_o      <= nrst_d;
      ctrl_lframe_o    <= lframe_d;
      ctrl_rd_status_o <= rd_d;
      ctrl_wr_status_o <= wr_d;
      rsp_valid_o      <= rsp_valid_d;
      rsp_error_o      <= rsp_error_d;
      rsp_data_o       <= rsp_data_d;
      busy_o           <= busy_d;
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q + CNT_W'(1);
    armed_n = armed_q;
    unique case (state_q)
      LPC_SEQ_ST_RST_HOLD: begin
        if (cnt_q == RST_LAST) begin
          state_n = LPC_SEQ_ST_RELEASE;
          cnt_n   = '0;
        end
      end
      LPC_SEQ_ST_RELEASE: begin
        if (host_idle) begin
          state_n = LPC_SEQ_ST_IDLE;
          cnt_n   = '0;
        end else if (cnt_q == TMO_LAST) begin
          state_n = LPC_SEQ_ST_RST_HOLD;
          cnt_n   = '0;
        end
      end
      LPC_SEQ_ST_IDLE: begin
        cnt_n = '0;
        if (accept) begin
          state_n = LPC_SEQ_ST_FRAME;
          armed_n = 1'b0;
        end
      end
      LPC_SEQ_ST_FRAME: state_n = LPC_SEQ_ST_STATUS;
      LPC_SEQ_ST_STATUS: begin
        state_n = LPC_SEQ_ST_WAIT;
        if (!ctrl_ready_i) armed_n = 1'b1;
      end
      LPC_SEQ_ST_WAIT: begin
        if (!ctrl_ready_i) armed_n = 1'b1;
        if (done) state_n = LPC_SEQ_ST_RESP_OK;
        else if (host_frst) state_n = LPC_SEQ_ST_RESP_ERR;
        else if (cnt_q == TMO_LAST) state_n = LPC_SEQ_ST_RESP_ERR;
      end
      LPC_SEQ_ST_RESP_OK: begin
        state_n = LPC_SEQ_ST_IDLE;
        cnt_n   = '0;
      end
      LPC_SEQ_ST_RESP_ERR: begin
        state_n = LPC_SEQ_ST_RST_HOLD;
        cnt_n   = '0;
      end
      default: begin
        state_n = LPC_SEQ_ST_RST_HOLD;
        cnt_n   = '0;
      end
    endcase
  end

  // outputs are decoded from the next state so they register alongside it
  always_comb begin
    req_d = req_q;
    if (accept) begin
      req_d.write  = req_write_i;
      req_d.memory = req_memory_i;
      req_d.addr   = req_addr_i;
      req_d.data   = req_data_i;
    end
    stat        = (state_n == LPC_SEQ_ST_STATUS) ||
                  (state_n == LPC_SEQ_ST_WAIT);
    nrst_d      = state_n != LPC_SEQ_ST_RST_HOLD;
    lframe_d    = state_n != LPC_SEQ_ST_FRAME;
    rd_d        = stat && !req_d.write;
    wr_d        = stat && req_d.write;
    rsp_valid_d = (state_n == LPC_SEQ_ST_RESP_OK) ||
                  (state_n == LPC_SEQ_ST_RESP_ERR);
    rsp_error_d = state_n == LPC_SEQ_ST_RESP_ERR;
    rsp_data_d  = '0;
    if (state_n == LPC_SEQ_ST_RESP_OK && !req_q.write)
      rsp_data_d = ctrl_data_i;
    busy_d      = state_n != LPC_SEQ_ST_IDLE;
  end

endmodule

// File: tb/tb_lpc_host_sequencer.sv
// Bench for lpc_host_sequencer: behavioural host plus table and
// random transactions scored against expected responses and timing.
module tb_lpc_host_sequencer;
  import lpc_host_sequencer_pkg::*;

  localparam int M_OK = 0, M_FORCE = 1, M_HANG = 2;
  localparam logic [4:0] H_RST = 5'h1f, H_BUSY = 5'h01, H_TAR = 5'h02;

  typedef struct {
    logic        w;
    logic        m;
    logic [15:0] a;
    logic [7:0]  d;
    int          mode;
    int          lat;
    logic [7:0]  hval;
    bit          hold;
    bit          b2b;
    logic        exp_err;
    logic [7:0]  exp_data;
  } txn_t;

  logic clk = 0;
  logic rst_i = 1;
  logic req_valid_i = 0, req_write_i = 0, req_memory_i = 0;
  logic [15:0] req_addr_i = 0;
  logic [7:0] req_data_i = 0;
  logic req_ready_o, rsp_valid_o, rsp_error_o, busy_o;
  logic [7:0] rsp_data_o, ctrl_data_o;
  logic [15:0] ctrl_addr_o;
  logic ctrl_nrst_o, ctrl_lframe_o, ctrl_rd_status_o;
  logic ctrl_wr_status_o, ctrl_memory_cycle_o;

  logic [4:0] hst = H_RST;
  logic hrdy = 1'b1;
  logic [7:0] hdat = 8'h00;
  int hph = 0, hcnt = 0;
  int h_mode = M_OK, h_lat = 4;
  logic [7:0] h_val = 8'h00;
  int cyc = 0, done_mark = 0, force_mark = 0, last_done = 0;
  int rsp_cnt = 0;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  lpc_host_sequencer dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_write_i(req_write_i), .req_memory_i(req_memory_i),
    .req_addr_i(req_addr_i), .req_data_i(req_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o),
    .rsp_error_o(rsp_error_o), .busy_o(busy_o),
    .ctrl_addr_o(ctrl_addr_o), .ctrl_data_o(ctrl_data_o),
    .ctrl_nrst_o(ctrl_nrst_o), .ctrl_lframe_o(ctrl_lframe_o),
    .ctrl_rd_status_o(ctrl_rd_status_o),
    .ctrl_wr_status_o(ctrl_wr_status_o),
    .ctrl_memory_cycle_o(ctrl_memory_cycle_o),
    .ctrl_data_i(hdat), .ctrl_ready_i(hrdy),
    .ctrl_host_state_i(hst)
  );

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (rsp_valid_o) rsp_cnt <= rsp_cnt + 1;

  // Host: idle after release, stale ready until two cycles into a frame
  always @(posedge clk) begin
    if (!ctrl_nrst_o) begin
      hph <= 0; hst <= H_RST; hrdy <= 1'b1; hcnt <= 0;
    end else begin
      case (hph)
        0: begin hst <= LPC_ST_IDLE; hph <= 1; end
        1: if (!ctrl_lframe_o) begin
          hst <= H_BUSY; hcnt <= 0; hph <= 2;
        end
        2: begin
          hcnt <= hcnt + 1;
          if (hcnt == 1) hrdy <= 1'b0;
          if (hcnt == h_lat && h_mode == M_OK) begin
            hrdy <= 1'b1;
            hdat <= ctrl_rd_status_o ? h_val : 8'($urandom);
            hst <= H_TAR; hcnt <= 0; hph <= 3;
            done_mark <= cyc + 1;
          end else if (hcnt == h_lat && h_mode == M_FORCE) begin
            hst <= LPC_ST_FORCE_RESET; hph <= 4;
            force_mark <= cyc + 1;
          end
        end
        3: begin
          hcnt <= hcnt + 1;
          if (hcnt == 1) begin hst <= LPC_ST_IDLE; hph <= 1; end
        end
        default: ;
      endcase
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic reset_seq(input string tag);
    int n = 0;
    int k = 0;
    while (!ctrl_nrst_o && n < 50) begin n++; tick; end
    chk({tag, "_nrst_low_cycles"}, n, 4);
    while (!req_ready_o && k < 150) begin k++; tick; end
    chk({tag, "_ready_after_release"}, k, 2);
  endtask

  function automatic void model(inout txn_t t);
    t.exp_err  = t.mode != M_OK;
    t.exp_data = (t.mode == M_OK && !t.w) ? t.hval : 8'h00;
  endfunction

  task automatic run_txn(input txn_t t, input string tag);
    int n = 0;
    int fcyc;
    int ecyc;
    h_mode = t.mode; h_lat = t.lat; h_val = t.hval;
    req_write_i = t.w; req_memory_i = t.m;
    req_addr_i = t.a; req_data_i = t.d; req_valid_i = 1;
    while (!req_ready_o && n < 300) begin n++; tick; end
    if (n >= 300) begin
      chk({tag, "_accept_timeout"}, 1, 0);
      req_valid_i = 0;
      return;
    end
    tick;
    if (!t.hold) req_valid_i = 0;
    fcyc = cyc;
    if (t.b2b) chk({tag, "_b2b_frame_cycle"}, fcyc, last_done + 3);
    chk({tag, "_lframe_low"}, ctrl_lframe_o, 0);
    chk({tag, "_frame_status"},
        {ctrl_rd_status_o, ctrl_wr_status_o}, 0);
    chk({tag, "_addr"}, ctrl_addr_o, t.a);
    chk({tag, "_data"}, ctrl_data_o, t.d);
    chk({tag, "_memory"}, ctrl_memory_cycle_o, t.m);
    tick;
    chk({tag, "_status"},
        {ctrl_lframe_o, ctrl_rd_status_o, ctrl_wr_status_o},
        {1'b1, !t.w, t.w});
    n = 0;
    while (!rsp_valid_o && n < 200) begin n++; tick; end
    if (n >= 200) begin
      chk({tag, "_rsp_timeout"}, 1, 0);
      return;
    end
    ecyc = (t.mode == M_OK)    ? done_mark + 1 :
           (t.mode == M_FORCE) ? force_mark + 1 : fcyc + 64;
    chk({tag, "_rsp_cycle"}, cyc, ecyc);
    chk({tag, "_rsp_error"}, rsp_error_o, t.exp_err);
    chk({tag, "_rsp_data"}, rsp_data_o, t.exp_data);
    tick;
    chk({tag, "_rsp_one_cycle"}, rsp_valid_o, 0);
    if (t.mode == M_OK) last_done = done_mark;
    else reset_seq({tag, "_recover"});
  endtask

  txn_t vec[8];
  txn_t t;
  int r, n, snap;

  initial begin
    vec[0] = '{0, 0, 16'h0C00, 8'h00, M_OK, 5, 8'hA5, 0, 0, 0, 8'hA5};
    vec[1] = '{1, 1, 16'hFED4, 8'h3C, M_OK, 6, 8'h77, 0, 0, 0, 8'h00};
    vec[2] = '{0, 0, 16'h0001, 8'h00, M_OK, 4, 8'h11, 1, 0, 0, 8'h11};
    vec[3] = '{0, 0, 16'h0002, 8'h00, M_OK, 7, 8'h22, 0, 1, 0, 8'h22};
    vec[4] = '{0, 0, 16'h0040, 8'h00, M_FORCE, 5, 8'h99, 0, 0, 1, 8'h00};
    vec[5] = '{0, 0, 16'h0C00, 8'h00, M_OK, 3, 8'h5A, 0, 0, 0, 8'h5A};
    vec[6] = '{1, 0, 16'h0080, 8'hE1, M_HANG, 0, 8'h00, 0, 0, 1, 8'h00};
    vec[7] = '{0, 1, 16'h1234, 8'h00, M_OK, 8, 8'hC3, 0, 0, 0, 8'hC3};

    tick;
    chk("reset_ctrl",
        {ctrl_nrst_o, ctrl_lframe_o, ctrl_rd_status_o,
         ctrl_wr_status_o, ctrl_memory_cycle_o}, 5'b01000);
    chk("reset_addr_data", {ctrl_addr_o, ctrl_data_o}, 0);
    chk("reset_rsp", {req_ready_o, rsp_valid_o, rsp_error_o, rsp_data_o}, 0);
    chk("reset_busy", busy_o, 1);
    tick; tick;
    rst_i = 0;
    reset_seq("init");
    chk("idle_not_busy", busy_o, 0);

    for (int i = 0; i < 8; i++) run_txn(vec[i], $sformatf("vec%0d", i));

    // reset mid-WAIT: no response, immediate return to reset hold
    h_mode = M_HANG;
    req_write_i = 0; req_addr_i = 16'h0300; req_valid_i = 1;
    n = 0;
    while (!req_ready_o && n < 300) begin n++; tick; end
    tick;
    req_valid_i = 0;
    repeat (10) tick;
    snap = rsp_cnt;
    rst_i = 1;
    tick;
    rst_i = 0;
    chk("midrst_ctrl",
        {ctrl_nrst_o, ctrl_lframe_o, ctrl_rd_status_o, rsp_valid_o},
        4'b0100);
    chk("midrst_addr", ctrl_addr_o, 0);
    reset_seq("midrst");
    chk("midrst_no_rsp", rsp_cnt, snap);

    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 19);
      t.w = 1'($urandom); t.m = 1'($urandom);
      t.a = 16'($urandom); t.d = 8'($urandom);
      t.mode = (r == 0) ? M_HANG : (r < 3) ? M_FORCE : M_OK;
      t.lat = $urandom_range(3, 20);
      t.hval = 8'($urandom);
      t.hold = 0; t.b2b = 0;
      model(t);
      run_txn(t, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
